// File: rtl/wr_pkg.sv
// Shared encodings for the write/receive control path.
// The top-level LED decoders use the same state codes.
package wr_pkg;

    localparam logic [2:0] LED_IDLE      = 3'd0;
    localparam logic [2:0] LED_WAIT_BYTE = 3'd1;
    localparam logic [2:0] LED_DONE      = 3'd2;
    localparam logic [2:0] LED_ERROR     = 3'd3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BYTE = 2'd1,
        DONE      = 2'd2,
        ERROR     = 2'd3
    } wr_state_e;

    function automatic logic [2:0] state_leds(input wr_state_e s);
        logic [2:0] code;
        code = LED_IDLE;
        case (s)
            IDLE:      code = LED_IDLE;
            WAIT_BYTE: code = LED_WAIT_BYTE;
            DONE:      code = LED_DONE;
            ERROR:     code = LED_ERROR;
            default:   code = LED_IDLE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/wr_control_if.sv
// Bundle between the UART RX core / sequencer and the frame receiver.
// The master side drives requests and bytes; the slave side is wr_control.
interface wr_control_if #(
    parameter int NBYTES = 11
);
    logic                  start_wr;
    logic                  rx_valid;
    logic [7:0]            rx_data;
    logic                  rx_err;
    logic                  busy;
    logic                  done_wr;
    logic                  err_wr;
    logic [NBYTES*8-1:0]   data_out;
    logic [2:0]            wr_leds;

    modport master (
        output start_wr, rx_valid, rx_data, rx_err,
        input  busy, done_wr, err_wr, data_out, wr_leds
    );

    modport slave (
        input  start_wr, rx_valid, rx_data, rx_err,
        output busy, done_wr, err_wr, data_out, wr_leds
    );
endinterface

// File: rtl/rx_byte_bank.sv
// Shadow shift register holding the frame under reception.
// next_bank is the value after a shift, so the owner can capture a frame as its last byte lands.
module rx_byte_bank #(
    parameter int NBYTES = 11
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                shift_en,
    input  logic [7:0]          byte_in,
    output logic [NBYTES*8-1:0] next_bank
);

    logic [NBYTES*8-1:0] bank;

    assign next_bank = {bank[NBYTES*8-9:0], byte_in};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank <= '0;
        end else if (clear) begin
            bank <= '0;
        end else if (shift_en) begin
            bank <= next_bank;
        end
    end

endmodule

// File: rtl/wr_control.sv
// Receives a fixed-length frame from the UART RX core and publishes it on data_out,
// aborting on a framing error or an inter-byte timeout.
module wr_control
    import wr_pkg::*;
#(
    parameter int NBYTES      = 11,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic         clk,
    input  logic         rst,
    wr_control_if.slave  bus
);

    localparam int BCW = $clog2(NBYTES + 1);
    localparam int TW  = $clog2(TIMEOUT_CYC);
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(NBYTES - 1);
    localparam logic [TW-1:0]  TMO_LAST  = TW'(TIMEOUT_CYC - 1);

    wr_state_e           state, state_next;
    logic [BCW-1:0]      bcnt, bcnt_next;
    logic [TW-1:0]       tcnt, tcnt_next;
    logic                bank_clear, bank_shift, capture;
    logic [NBYTES*8-1:0] next_bank;

    rx_byte_bank #(.NBYTES(NBYTES)) u_bank (
        .clk       (clk),
        .rst       (rst),
        .clear     (bank_clear),
        .shift_en  (bank_shift),
        .byte_in   (bus.rx_data),
        .next_bank (next_bank)
    );

    always_comb begin
        state_next = state;
        bcnt_next  = bcnt;
        tcnt_next  = tcnt;
        bank_clear = 1'b0;
        bank_shift = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start_wr) begin
                    state_next = WAIT_BYTE;
                    bcnt_next  = '0;
                    tcnt_next  = '0;
                    bank_clear = 1'b1;
                end
            end
            WAIT_BYTE: begin
                // Error beats a byte, and a byte beats an expiring timeout.
                if (bus.rx_err) begin
                    state_next = ERROR;
                end else if (bus.rx_valid) begin
                    bank_shift = 1'b1;
                    bcnt_next  = bcnt + BCW'(1);
                    tcnt_next  = '0;
                    if (bcnt == LAST_BYTE) begin
                        state_next = DONE;
                        capture    = 1'b1;
                    end
                end else if (tcnt == TMO_LAST) begin
                    state_next = ERROR;
                end else begin
                    tcnt_next = tcnt + TW'(1);
                end
            end
            DONE:    state_next = IDLE;
            ERROR:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            bcnt         <= '0;
            tcnt         <= '0;
            bus.busy     <= 1'b0;
            bus.done_wr  <= 1'b0;
            bus.err_wr   <= 1'b0;
            bus.wr_leds  <= LED_IDLE;
            bus.data_out <= '0;
        end else begin
            state        <= state_next;
            bcnt         <= bcnt_next;
            tcnt         <= tcnt_next;
            bus.busy     <= (state_next == WAIT_BYTE);
            bus.done_wr  <= (state_next == DONE);
            bus.err_wr   <= (state_next == ERROR);
            bus.wr_leds  <= state_leds(state_next);
            if (capture) begin
                bus.data_out <= next_bank;
            end
        end
    end

endmodule
